// File: rtl/synth_pkg.sv
// Shared constants and types for the synthesiser voice blocks.
package synth_pkg;

  localparam logic [15:0] DEFAULT_DIV = 16'd38223;  // low C at 10 MHz
  localparam int          MIN_DIV     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } osc_state_t;

endpackage

// File: rtl/note_oscillator_if.sv
// Control and audio signals between a voice controller and note_oscillator.
interface note_oscillator_if
  import synth_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMP_W = 8
);

  // Level-signalled, no valid/ready: en is a held key request and divisor a held
  // period count; both may change at any time relative to clk and are synchronised
  // inside the oscillator. Outputs are continuous, with period_start a 1-cycle pulse.
  logic             en;
  logic [WIDTH-1:0] divisor;
  logic             wave_out;
  logic [AMP_W-1:0] sample;
  logic             period_start;
  logic             busy;
  osc_state_t       state_dbg;

  modport master (
    output en, divisor,
    input  wave_out, sample, period_start, busy, state_dbg
  );

  modport slave (
    input  en, divisor,
    output wave_out, sample, period_start, busy, state_dbg
  );

endinterface

// File: rtl/bus_stabilizer.sv
// Accepts an asynchronous multi-bit bus only after two identical consecutive samples,
// so a value caught mid-transition is never passed on.
module bus_stabilizer #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] stable
);

  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             v1;
  logic             v2;

  // v1/v2 keep the reset-cleared sample pair from being accepted as a real value.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      d1     <= '0;
      d2     <= '0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      stable <= RST_VAL;
    end else begin
      d1 <= bus;
      d2 <= d1;
      v1 <= 1'b1;
      v2 <= v1;
      if (v2 && (d1 == d2)) stable <= d2;
    end
  end

endmodule

// File: rtl/note_oscillator.sv
// Single-voice square-wave generator; period changes and key release take effect
// only at period boundaries.
module note_oscillator
  import synth_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter int               AMP_W   = 8,
  parameter logic [AMP_W-1:0] AMP_MAX = 8'hFF
) (
  input  logic               clk,
  input  logic               nrst,
  note_oscillator_if.slave   osc
);

  logic             en_m;
  logic             en_s;
  logic [WIDTH-1:0] div_stable;
  logic [WIDTH-1:0] eff;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_q_nx;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nx;
  logic             wrap;
  logic             busy;
  osc_state_t       state;
  osc_state_t       state_nx;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      en_m <= 1'b0;
      en_s <= 1'b0;
    end else begin
      en_m <= osc.en;
      en_s <= en_m;
    end
  end

  bus_stabilizer #(
    .WIDTH   (WIDTH),
    .RST_VAL (WIDTH'(DEFAULT_DIV))
  ) u_div_filter (
    .clk    (clk),
    .nrst   (nrst),
    .bus    (osc.divisor),
    .stable (div_stable)
  );

  assign eff  = (div_stable < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : div_stable;
  assign wrap = (count == (div_q - WIDTH'(1)));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      count <= '0;
      div_q <= WIDTH'(DEFAULT_DIV);
    end else begin
      state <= state_nx;
      count <= count_nx;
      div_q <= div_q_nx;
    end
  end

  // A release during the last cycle of a period still reloads and plays one full
  // period in DRAIN; re-pressing in DRAIN resumes RUN without touching the phase.
  always_comb begin
    state_nx = state;
    count_nx = count;
    div_q_nx = div_q;
    case (state)
      IDLE: begin
        if (en_s) begin
          state_nx = RUN;
          count_nx = '0;
          div_q_nx = eff;
        end
      end
      RUN, DRAIN: begin
        if (wrap) begin
          count_nx = '0;
          div_q_nx = eff;
        end else begin
          count_nx = count + WIDTH'(1);
        end
        if (en_s)                       state_nx = RUN;
        else if ((state == DRAIN) && wrap) state_nx = IDLE;
        else                            state_nx = DRAIN;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy             = (state != IDLE);
  assign osc.busy         = busy;
  assign osc.wave_out     = busy && (count < (div_q >> 1));
  assign osc.sample       = osc.wave_out ? AMP_MAX : '0;
  assign osc.period_start = busy && (count == '0);
  assign osc.state_dbg    = state;

endmodule

// File: tb/tb_note_oscillator.sv
// Randomised and directed stimulus for note_oscillator against a period-level model.
module tb_note_oscillator;
  import synth_pkg::*;

  logic clk;
  logic nrst;
  note_oscillator_if osc_if ();

  note_oscillator u_dut (
    .clk  (clk),
    .nrst (nrst),
    .osc  (osc_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #50 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The voice is described as a sequence of periods: each has a length and an
  // elapsed-cycle counter; the key is seen two edges late, the divisor only
  // after two matching samples, and the voice stops at the end of a period once
  // the synced key has been low on two consecutive edges.
  logic [15:0] exp_q[$];
  bit          m_busy;
  bit          m_drain;
  int unsigned m_len;
  int unsigned m_el;
  logic [15:0] m_stable;
  logic [15:0] h1, h2;
  int          n_hist;
  bit          e1, e2, e3;

  task automatic model_reset();
    m_busy = 0; m_drain = 0; m_len = 0; m_el = 0;
    m_stable = DEFAULT_DIV;
    h1 = '0; h2 = '0; n_hist = 0;
    e1 = 0; e2 = 0; e3 = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit          ens_now;
    bit          ens_prev;
    int unsigned eff;
    ens_now  = e2;
    ens_prev = e3;
    eff      = (m_stable < 16'd2) ? 2 : int'(m_stable);
    if (!m_busy) begin
      if (ens_now) begin
        m_busy = 1; m_el = 0; m_len = eff;
        exp_q.push_back(16'(eff));
      end
    end else if (m_el == m_len - 1) begin
      m_el = 0;
      if (!ens_now && !ens_prev) m_busy = 0;
      else begin
        m_len = eff;
        exp_q.push_back(16'(eff));
      end
    end else begin
      m_el++;
    end
    m_drain = m_busy && !ens_now;
    if (n_hist >= 2 && h1 == h2) m_stable = h1;
    h2 = h1;
    h1 = osc_if.divisor;
    if (n_hist < 2) n_hist++;
    e3 = e2;
    e2 = e1;
    e1 = osc_if.en;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) model_reset();
      else       model_step();
    end
  end

  // ---------------- cycle checker ----------------
  bit         ew;
  osc_state_t es;
  always @(negedge clk) begin
    if (chk_on) begin
      ew = m_busy && (m_el < m_len / 2);
      es = !m_busy ? IDLE : (m_drain ? DRAIN : RUN);
      check("wave_out",     32'(osc_if.wave_out),     32'(ew));
      check("sample",       32'(osc_if.sample),       ew ? 32'hFF : 32'h0);
      check("period_start", 32'(osc_if.period_start), 32'(m_busy && m_el == 0));
      check("busy",         32'(osc_if.busy),         32'(m_busy));
      check("state",        32'(osc_if.state_dbg),    32'(es));
    end
  end

  // ---------------- period scoreboard ----------------
  bit meas_on  = 0;
  int meas_len = 0;

  task automatic close_period();
    if (exp_q.size() == 0) check("period_q_size", 32'(exp_q.size()), 32'd1);
    else                   check("period_len", 32'(meas_len), 32'(exp_q.pop_front()));
  endtask

  always @(negedge clk) begin
    if (!nrst) begin
      meas_on = 0;
    end else if (osc_if.period_start) begin
      if (meas_on) close_period();
      meas_on  = 1;
      meas_len = 1;
    end else if (meas_on) begin
      if (osc_if.busy) meas_len++;
      else begin
        close_period();
        meas_on = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_div(input int d);
    osc_if.divisor = 16'(d);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wave"},  32'(osc_if.wave_out),     32'd0);
    check({tag, "_smp"},   32'(osc_if.sample),       32'd0);
    check({tag, "_ps"},    32'(osc_if.period_start), 32'd0);
    check({tag, "_busy"},  32'(osc_if.busy),         32'd0);
    check({tag, "_state"}, 32'(osc_if.state_dbg),    32'(IDLE));
  endtask

  initial begin
    #(100 * 95000);
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    nrst = 1'b1;
    osc_if.en = 1'b0;
    set_div(10);
    #10 nrst = 1'b0;
    chk_on = 1;
    #1 check_all_zero("reset");
    step(3);
    nrst = 1'b1;
    step(5);

    // divisor 10: 5 high / 5 low, release somewhere mid-period
    osc_if.en = 1'b1;
    step(35);
    osc_if.en = 1'b0;
    step(20);
    check("idle_after_10", 32'(osc_if.busy), 32'd0);

    // divisor 7: 3 high / 4 low
    set_div(7);
    step(4);
    osc_if.en = 1'b1;
    step(30);
    osc_if.en = 1'b0;
    step(15);

    // divisors 0 then 1 clamp to a period of 2
    set_div(0);
    step(4);
    osc_if.en = 1'b1;
    step(12);
    set_div(1);
    step(12);
    osc_if.en = 1'b0;
    step(8);

    // 10 -> 4 at count 3 of the first period
    set_div(10);
    step(4);
    osc_if.en = 1'b1;
    step(6);
    set_div(4);
    step(30);
    // release at count 2 of a 10 period
    set_div(10);
    step(14);
    osc_if.en = 1'b0;
    step(20);
    check("idle_after_drain", 32'(osc_if.busy), 32'd0);

    // re-press during DRAIN keeps periods continuous
    osc_if.en = 1'b1;
    step(23);
    osc_if.en = 1'b0;
    step(3);
    osc_if.en = 1'b1;
    step(25);
    osc_if.en = 1'b0;
    step(15);

    // randomised traffic, including a divisor that changes every cycle
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: set_div(int'($urandom_range(0, 24)));
        1: osc_if.en = ~osc_if.en;
        2: begin
          repeat ($urandom_range(3, 10)) begin
            osc_if.divisor = osc_if.divisor ^ 16'($urandom_range(1, 15));
            step(1);
          end
        end
        default: begin
          set_div(int'($urandom_range(2, 40)));
          osc_if.en = 1'b1;
        end
      endcase
      step(int'($urandom_range(1, 25)));
    end
    osc_if.en = 1'b0;
    step(50);
    check("idle_after_random", 32'(osc_if.busy), 32'd0);

    // reset pulse mid-RUN, key held through it
    set_div(12);
    step(4);
    osc_if.en = 1'b1;
    step(17);
    #20 nrst = 1'b0;
    #1 check_all_zero("midrst");
    step(2);
    nrst = 1'b1;
    step(2);
    check("restart_wait", 32'(osc_if.busy), 32'd0);
    step(1);
    check("restart_busy", 32'(osc_if.busy), 32'd1);
    step(38223 + 40);
    osc_if.en = 1'b0;
    step(40);
    check("final_busy", 32'(osc_if.busy), 32'd0);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
